// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one line-wide memory port among NUM_REQ cache
// controllers; one transaction in flight, priority rotates after each one.
module mem_arbiter #(
  parameter int NUM_REQ         = 2,
  parameter int ADDRESS_WIDTH   = 32,
  parameter int CACHE_LINE_SIZE = 32,
  parameter int TIMEOUT_CYCLES  = 255
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         reqValid_REQ,
  input  logic [ADDRESS_WIDTH-1:0]   reqAddress_REQ [NUM_REQ],
  input  logic [CACHE_LINE_SIZE-1:0] reqDataIn_REQ  [NUM_REQ],
  input  logic [NUM_REQ-1:0]         reqWen_REQ,
  output logic [NUM_REQ-1:0]         respValid_REQ,
  output logic [CACHE_LINE_SIZE-1:0] respDataOut_REQ,
  output logic [NUM_REQ-1:0]         grant,
  output logic                       reqValid_MEM,
  output logic [ADDRESS_WIDTH-1:0]   reqAddress_MEM,
  output logic [CACHE_LINE_SIZE-1:0] reqDataOut_MEM,
  output logic                       reqWen_MEM,
  input  logic                       respValid_MEM,
  input  logic [CACHE_LINE_SIZE-1:0] respDataIn_MEM,
  output logic                       timeout_MEM
);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RESP, RELEASE} state_t;

  state_t                     state;
  logic [IW-1:0]              rr_pointer;
  logic [IW-1:0]              owner;
  logic [IW-1:0]              win_idx;
  logic [CW-1:0]              wait_count;
  logic [CACHE_LINE_SIZE-1:0] resp_data;
  logic                       any_req;
  logic                       complete;
  int unsigned                scan_idx;

  // First requester at or after rr_pointer, wrapping around.
  always_comb begin
    any_req  = 1'b0;
    win_idx  = '0;
    scan_idx = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      scan_idx = (32'(rr_pointer) + k) % NUM_REQ;
      if (!any_req && reqValid_REQ[IW'(scan_idx)]) begin
        any_req = 1'b1;
        win_idx = IW'(scan_idx);
      end
    end
  end

  assign complete        = ((state == ISSUE) || (state == WAIT_RESP)) && respValid_MEM;
  assign respValid_REQ   = complete ? grant : '0;
  assign respDataOut_REQ = complete ? respDataIn_MEM : resp_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      grant          <= '0;
      reqValid_MEM   <= 1'b0;
      reqWen_MEM     <= 1'b0;
      reqAddress_MEM <= '0;
      reqDataOut_MEM <= '0;
      resp_data      <= '0;
      rr_pointer     <= '0;
      owner          <= '0;
      wait_count     <= '0;
      timeout_MEM    <= 1'b0;
    end else begin
      if (complete) resp_data <= respDataIn_MEM;
      unique case (state)
        IDLE: begin
          if (any_req) begin
            state          <= ISSUE;
            owner          <= win_idx;
            grant          <= NUM_REQ'(1) << win_idx;
            reqValid_MEM   <= 1'b1;
            reqAddress_MEM <= reqAddress_REQ[win_idx];
            reqDataOut_MEM <= reqDataIn_REQ[win_idx];
            reqWen_MEM     <= reqWen_REQ[win_idx];
          end
        end
        ISSUE: begin
          if (respValid_MEM) begin
            state        <= RELEASE;
            reqValid_MEM <= 1'b0;
            grant        <= '0;
          end else begin
            state <= WAIT_RESP;
          end
        end
        WAIT_RESP: begin
          if (wait_count != CW'(TIMEOUT_CYCLES)) wait_count <= wait_count + CW'(1);
          // Flag raised on the edge where the count arrives at the limit.
          if (wait_count >= CW'(TIMEOUT_CYCLES - 1)) timeout_MEM <= 1'b1;
          if (respValid_MEM) begin
            state        <= RELEASE;
            reqValid_MEM <= 1'b0;
            grant        <= '0;
          end
        end
        RELEASE: begin
          state      <= IDLE;
          rr_pointer <= IW'((32'(owner) + 32'd1) % NUM_REQ);
          wait_count <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized
// transactions checked against a transaction-level round-robin model.
module tb_mem_arbiter;
  localparam int N  = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req_valid;
  logic [AW-1:0] req_addr [N];
  logic [DW-1:0] req_data [N];
  logic [N-1:0]  req_wen;
  logic [N-1:0]  resp_valid;
  logic [DW-1:0] resp_data;
  logic [N-1:0]  grant;
  logic          mem_valid;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_wen;
  logic          mem_resp_valid;
  logic [DW-1:0] mem_resp_data;
  logic          timeout;

  int checks = 0;
  int errors = 0;

  mem_arbiter #(
    .NUM_REQ(N), .ADDRESS_WIDTH(AW), .CACHE_LINE_SIZE(DW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .reqValid_REQ(req_valid), .reqAddress_REQ(req_addr), .reqDataIn_REQ(req_data),
    .reqWen_REQ(req_wen), .respValid_REQ(resp_valid), .respDataOut_REQ(resp_data),
    .grant(grant), .reqValid_MEM(mem_valid), .reqAddress_MEM(mem_addr),
    .reqDataOut_MEM(mem_wdata), .reqWen_MEM(mem_wen), .respValid_MEM(mem_resp_valid),
    .respDataIn_MEM(mem_resp_data), .timeout_MEM(timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    req_valid = '0;
    req_wen   = '0;
    for (int i = 0; i < N; i++) begin
      req_addr[i] = '0;
      req_data[i] = '0;
    end
    mem_resp_valid = 1'b0;
    mem_resp_data  = '0;
  endtask

  task automatic apply_reset();
    clear_inputs();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    sample();
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL reset_grant: got %b want 00", grant); end
    checks++; if (resp_valid !== 2'b00) begin errors++; $display("FAIL reset_resp_valid: got %b want 00", resp_valid); end
    checks++; if ({mem_valid, mem_wen} !== 2'b00) begin errors++; $display("FAIL reset_mem_ctl: got %b want 00", {mem_valid, mem_wen}); end
    checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL reset_mem_addr: got %h want 0", mem_addr); end
    checks++; if (mem_wdata !== 32'h0) begin errors++; $display("FAIL reset_mem_wdata: got %h want 0", mem_wdata); end
    checks++; if (resp_data !== 32'h0) begin errors++; $display("FAIL reset_resp_data: got %h want 0", resp_data); end
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %b want 0", timeout); end
    next_cycle();
  endtask

  task automatic test_single_read();
    apply_reset();
    req_valid = 2'b01; req_addr[0] = 32'h100; req_data[0] = 32'h1234; req_wen = 2'b00;
    sample();
    checks++; if (mem_valid !== 1'b0) begin errors++; $display("FAIL single_c0_mem_valid: got %b want 0", mem_valid); end
    next_cycle(); sample();
    checks++; if (mem_valid !== 1'b1) begin errors++; $display("FAIL single_c1_mem_valid: got %b want 1", mem_valid); end
    checks++; if (mem_addr !== 32'h100) begin errors++; $display("FAIL single_c1_addr: got %h want 100", mem_addr); end
    checks++; if (mem_wen !== 1'b0) begin errors++; $display("FAIL single_c1_wen: got %b want 0", mem_wen); end
    checks++; if (grant !== 2'b01) begin errors++; $display("FAIL single_c1_grant: got %b want 01", grant); end
    next_cycle(); sample();
    checks++; if ({mem_valid, resp_valid} !== 3'b100) begin errors++; $display("FAIL single_c2_wait: got %b want 100", {mem_valid, resp_valid}); end
    next_cycle();
    mem_resp_valid = 1'b1; mem_resp_data = 32'hDEADBEEF;
    sample();
    checks++; if (resp_valid !== 2'b01) begin errors++; $display("FAIL single_c3_resp_valid: got %b want 01", resp_valid); end
    checks++; if (resp_data !== 32'hDEADBEEF) begin errors++; $display("FAIL single_c3_resp_data: got %h want deadbeef", resp_data); end
    next_cycle();
    mem_resp_valid = 1'b0; mem_resp_data = 32'h0; req_valid = 2'b00;
    sample();
    checks++; if ({grant, mem_valid} !== 3'b000) begin errors++; $display("FAIL single_c4_release: got %b want 000", {grant, mem_valid}); end
    checks++; if (resp_data !== 32'hDEADBEEF) begin errors++; $display("FAIL single_c4_resp_data: got %h want deadbeef", resp_data); end
    next_cycle();
    req_valid = 2'b10; req_addr[1] = 32'h200;
    sample();
    checks++; if (resp_data !== 32'hDEADBEEF) begin errors++; $display("FAIL single_c5_resp_data: got %h want deadbeef", resp_data); end
    next_cycle();
    mem_resp_valid = 1'b1; mem_resp_data = 32'hCAFEF00D;
    sample();
    checks++; if (grant !== 2'b10) begin errors++; $display("FAIL single_c6_grant: got %b want 10", grant); end
    checks++; if (mem_addr !== 32'h200) begin errors++; $display("FAIL single_c6_addr: got %h want 200", mem_addr); end
    checks++; if (resp_valid !== 2'b10) begin errors++; $display("FAIL single_c6_zero_lat_resp: got %b want 10", resp_valid); end
    checks++; if (resp_data !== 32'hCAFEF00D) begin errors++; $display("FAIL single_c6_resp_data: got %h want cafef00d", resp_data); end
    next_cycle();
    mem_resp_valid = 1'b0; req_valid = 2'b00;
    sample();
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL single_c7_grant: got %b want 00", grant); end
    next_cycle();
  endtask

  task automatic test_simultaneous();
    apply_reset();
    req_valid = 2'b11; req_addr[0] = 32'h10; req_addr[1] = 32'h20;
    next_cycle(); sample();
    checks++; if (grant !== 2'b01) begin errors++; $display("FAIL simul_first_grant: got %b want 01", grant); end
    checks++; if (mem_addr !== 32'h10) begin errors++; $display("FAIL simul_first_addr: got %h want 10", mem_addr); end
    next_cycle();
    mem_resp_valid = 1'b1; mem_resp_data = 32'hA1A1A1A1;
    sample();
    checks++; if (resp_valid !== 2'b01) begin errors++; $display("FAIL simul_first_resp: got %b want 01", resp_valid); end
    next_cycle();
    mem_resp_valid = 1'b0; req_valid = 2'b10;
    sample();
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL simul_release_grant: got %b want 00", grant); end
    next_cycle(); sample();
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL simul_idle_grant: got %b want 00", grant); end
    next_cycle();
    mem_resp_valid = 1'b1; mem_resp_data = 32'hB2B2B2B2;
    sample();
    checks++; if (grant !== 2'b10) begin errors++; $display("FAIL simul_second_grant: got %b want 10", grant); end
    checks++; if (mem_addr !== 32'h20) begin errors++; $display("FAIL simul_second_addr: got %h want 20", mem_addr); end
    checks++; if (resp_valid !== 2'b10) begin errors++; $display("FAIL simul_second_resp: got %b want 10", resp_valid); end
    next_cycle();
    mem_resp_valid = 1'b0; req_valid = 2'b00;
    next_cycle();
  endtask

  task automatic test_fairness();
    logic [1:0] exp_g;
    apply_reset();
    req_valid = 2'b11; req_addr[0] = 32'hA0; req_addr[1] = 32'hB0;
    for (int t = 0; t < 4; t++) begin
      exp_g = (t % 2 == 0) ? 2'b01 : 2'b10;
      sample();
      checks++; if (grant !== 2'b00) begin errors++; $display("FAIL fair_idle_%0d: got %b want 00", t, grant); end
      next_cycle();
      mem_resp_valid = 1'b1; mem_resp_data = 32'(t + 100);
      sample();
      checks++; if (grant !== exp_g) begin errors++; $display("FAIL fair_grant_%0d: got %b want %b", t, grant, exp_g); end
      checks++; if (resp_valid !== exp_g) begin errors++; $display("FAIL fair_resp_%0d: got %b want %b", t, resp_valid, exp_g); end
      next_cycle();
      mem_resp_valid = 1'b0;
      sample();
      checks++; if (grant !== 2'b00) begin errors++; $display("FAIL fair_release_%0d: got %b want 00", t, grant); end
      next_cycle();
    end
    req_valid = 2'b00;
    next_cycle();
  endtask

  task automatic test_write();
    apply_reset();
    req_valid = 2'b10; req_wen = 2'b10;
    req_addr[1] = 32'h40; req_data[1] = 32'h5A5A5A5A;
    req_addr[0] = 32'h77; req_data[0] = 32'h11;
    next_cycle();
    for (int c = 1; c <= 3; c++) begin
      if (c == 1) begin
        sample();
      end else begin
        if (c == 3) begin mem_resp_valid = 1'b1; mem_resp_data = 32'h0BADC0DE; end
        sample();
      end
      checks++; if (mem_wen !== 1'b1) begin errors++; $display("FAIL write_wen_c%0d: got %b want 1", c, mem_wen); end
      checks++; if (mem_wdata !== 32'h5A5A5A5A) begin errors++; $display("FAIL write_data_c%0d: got %h want 5a5a5a5a", c, mem_wdata); end
      checks++; if (mem_addr !== 32'h40) begin errors++; $display("FAIL write_addr_c%0d: got %h want 40", c, mem_addr); end
      checks++; if (grant !== 2'b10) begin errors++; $display("FAIL write_grant_c%0d: got %b want 10", c, grant); end
      // Requester changes everything, including dropping its request, after the grant.
      req_data[1] = 32'hFFFF0000; req_addr[1] = 32'h999; req_wen = 2'b00; req_valid = 2'b00;
      next_cycle();
    end
    mem_resp_valid = 1'b0;
    next_cycle();
  endtask

  task automatic test_write_resp();
    // Response to a requester that dropped its request mid-transaction.
    apply_reset();
    req_valid = 2'b10; req_wen = 2'b10; req_addr[1] = 32'h44; req_data[1] = 32'h1;
    next_cycle();
    req_valid = 2'b00;
    next_cycle();
    mem_resp_valid = 1'b1; mem_resp_data = 32'h600DF00D;
    sample();
    checks++; if (resp_valid !== 2'b10) begin errors++; $display("FAIL dropped_req_resp: got %b want 10", resp_valid); end
    next_cycle();
    mem_resp_valid = 1'b0;
    next_cycle();
  endtask

  task automatic test_reset_mid();
    apply_reset();
    req_valid = 2'b01; req_addr[0] = 32'h300;
    next_cycle(); next_cycle(); sample();
    checks++; if (mem_valid !== 1'b1) begin errors++; $display("FAIL rstmid_wait_valid: got %b want 1", mem_valid); end
    rst = 1'b1;
    next_cycle();
    rst = 1'b0; req_valid = 2'b00; mem_resp_valid = 1'b1; mem_resp_data = 32'h55555555;
    sample();
    checks++; if (mem_valid !== 1'b0) begin errors++; $display("FAIL rstmid_mem_valid: got %b want 0", mem_valid); end
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL rstmid_grant: got %b want 00", grant); end
    checks++; if (resp_valid !== 2'b00) begin errors++; $display("FAIL rstmid_resp_valid: got %b want 00", resp_valid); end
    next_cycle();
    mem_resp_valid = 1'b0;
    sample();
    checks++; if (resp_data !== 32'h0) begin errors++; $display("FAIL rstmid_no_capture: got %h want 0", resp_data); end
    next_cycle();
  endtask

  task automatic test_random();
    logic [N-1:0]  pend;
    logic [N-1:0]  ew;
    logic [N-1:0]  exp_g;
    logic [N-1:0]  exp_rv;
    logic [AW-1:0] ea [N];
    logic [DW-1:0] ed [N];
    logic [DW-1:0] last_rd;
    logic [DW-1:0] rd;
    int ptr;
    int w;
    int lat;
    apply_reset();
    pend = '0; ew = '0; ptr = 0; last_rd = '0;
    for (int i = 0; i < N; i++) begin ea[i] = '0; ed[i] = '0; end
    for (int t = 0; t < 40; t++) begin
      for (int c = 0; c < 4; c++) begin
        for (int i = 0; i < N; i++) begin
          if (!pend[i] && ($urandom_range(0, 1) == 1 || c == 3)) begin
            pend[i] = 1'b1; ea[i] = $urandom; ed[i] = $urandom; ew[i] = 1'($urandom_range(0, 1));
            req_addr[i] = ea[i]; req_data[i] = ed[i]; req_wen[i] = ew[i];
          end
        end
        req_valid = pend;
        mem_resp_valid = 1'($urandom_range(0, 1)); mem_resp_data = $urandom;
        sample();
        checks++; if ({grant, resp_valid} !== '0) begin errors++; $display("FAIL rnd_idle_%0d: got %b want 0", t, {grant, resp_valid}); end
        checks++; if (resp_data !== last_rd) begin errors++; $display("FAIL rnd_idle_data_%0d: got %h want %h", t, resp_data, last_rd); end
        next_cycle();
        if (pend != '0) break;
      end
      w = -1;
      for (int k = 0; k < N; k++) if (w < 0 && pend[(ptr + k) % N]) w = (ptr + k) % N;
      exp_g = '0; exp_g[w] = 1'b1;
      lat = int'($urandom_range(0, 3));
      rd = $urandom;
      for (int c = 0; c <= lat; c++) begin
        mem_resp_valid = (c == lat); mem_resp_data = (c == lat) ? rd : $urandom;
        if (c > 0) begin
          req_addr[w] = $urandom; req_data[w] = $urandom; req_wen[w] = 1'($urandom_range(0, 1));
        end
        exp_rv = (c == lat) ? exp_g : '0;
        sample();
        checks++; if ({grant, mem_valid} !== {exp_g, 1'b1}) begin errors++; $display("FAIL rnd_busy_grant_%0d: got %b want %b", t, {grant, mem_valid}, {exp_g, 1'b1}); end
        checks++; if ({mem_addr, mem_wdata, mem_wen} !== {ea[w], ed[w], ew[w]}) begin errors++; $display("FAIL rnd_busy_port_%0d: got %h/%h/%b want %h/%h/%b", t, mem_addr, mem_wdata, mem_wen, ea[w], ed[w], ew[w]); end
        checks++; if (resp_valid !== exp_rv) begin errors++; $display("FAIL rnd_resp_valid_%0d: got %b want %b", t, resp_valid, exp_rv); end
        checks++; if (resp_data !== ((c == lat) ? rd : last_rd)) begin errors++; $display("FAIL rnd_resp_data_%0d: got %h want %h", t, resp_data, (c == lat) ? rd : last_rd); end
        next_cycle();
      end
      last_rd = rd;
      pend[w] = 1'b0; req_valid = pend;
      mem_resp_valid = 1'($urandom_range(0, 1)); mem_resp_data = $urandom;
      sample();
      checks++; if ({grant, mem_valid, resp_valid} !== '0) begin errors++; $display("FAIL rnd_release_%0d: got %b want 0", t, {grant, mem_valid, resp_valid}); end
      checks++; if (resp_data !== last_rd) begin errors++; $display("FAIL rnd_release_data_%0d: got %h want %h", t, resp_data, last_rd); end
      ptr = (w + 1) % N;
      next_cycle();
    end
    sample();
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL rnd_no_timeout: got %b want 0", timeout); end
    clear_inputs();
    next_cycle();
  endtask

  task automatic test_timeout();
    apply_reset();
    req_valid = 2'b01; req_addr[0] = 32'h500;
    next_cycle();
    for (int c = 1; c <= 8; c++) begin
      sample();
      checks++; if (timeout !== (c >= 6)) begin errors++; $display("FAIL timeout_c%0d: got %b want %b", c, timeout, (c >= 6)); end
      checks++; if ({mem_valid, resp_valid} !== 3'b100) begin errors++; $display("FAIL timeout_wait_c%0d: got %b want 100", c, {mem_valid, resp_valid}); end
      next_cycle();
    end
    mem_resp_valid = 1'b1; mem_resp_data = 32'h77777777;
    sample();
    checks++; if (resp_valid !== 2'b01) begin errors++; $display("FAIL timeout_late_resp: got %b want 01", resp_valid); end
    checks++; if (resp_data !== 32'h77777777) begin errors++; $display("FAIL timeout_late_data: got %h want 77777777", resp_data); end
    next_cycle();
    mem_resp_valid = 1'b0; req_valid = 2'b00;
    sample();
    checks++; if ({grant, timeout} !== 3'b001) begin errors++; $display("FAIL timeout_release: got %b want 001", {grant, timeout}); end
    next_cycle(); sample();
    checks++; if ({mem_valid, timeout} !== 2'b01) begin errors++; $display("FAIL timeout_sticky: got %b want 01", {mem_valid, timeout}); end
    next_cycle();
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_single_read();
    test_simultaneous();
    test_fairness();
    test_write();
    test_write_resp();
    test_reset_mid();
    test_random();
    test_timeout();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
